// File: rtl/blk_e53820.sv
// On-chip RAM stream reader: on a start command, reads a contiguous word region
// from a single-port RAM with 1-cycle read latency and emits the words as a
// ready/valid stream with SOP/EOP. Read requests are credit-limited so the
// output FIFO can never overflow under backpressure.
module blk_e53820 #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   ram_address,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready,
    output logic                st_sop,
    output logic                st_eop
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [ADDR_W:0] LastWord = (ADDR_W + 1)'(1);
    localparam logic [CW-1:0]   DepthCw  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic                first_q, first_d;
    logic                done_q, done_d;

    // One read may be outstanding; its SOP/EOP tags travel with it.
    logic                inflight_q;
    logic                infl_sop_q;
    logic                infl_eop_q;

    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic                fifo_sop_q  [FIFO_DEPTH];
    logic                fifo_eop_q  [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;

    logic                req;
    logic                push;
    logic                pop;
    logic                head_eop;
    logic [CW-1:0]       credit_used;

    // Credit accounting: words already buffered plus the one in flight.
    always_comb begin
        credit_used = count_q + CW'(inflight_q);
        req         = (state_q == StRead) && (remaining_q != '0) && (credit_used < DepthCw);
        push        = inflight_q;
        st_valid    = (count_q != '0);
        pop         = st_valid && st_ready;
        head_eop    = fifo_eop_q[rd_ptr_q];
    end

    // Next-state logic for the IDLE -> READ -> DRAIN sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (word_count != '0) begin
                        addr_d      = base_addr;
                        remaining_d = word_count;
                        first_d     = 1'b1;
                        state_d     = StRead;
                    end else begin
                        // Empty transfer completes immediately without touching the RAM.
                        done_d = 1'b1;
                    end
                end
            end
            StRead: begin
                if (req) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    first_d     = 1'b0;
                    if (remaining_q == LastWord) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // The EOP word is the last one, so its acceptance implies
                // nothing in flight and an empty FIFO afterwards.
                if (pop && head_eop) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer state, address/length counters and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            done_q      <= done_d;
        end
    end

    // Track the outstanding read so its data is captured one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            infl_sop_q <= 1'b0;
            infl_eop_q <= 1'b0;
        end else begin
            inflight_q <= req;
            infl_sop_q <= req && first_q;
            infl_eop_q <= req && (remaining_q == LastWord);
        end
    end

    // Output FIFO storage and pointers; the head entry drives the stream directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_sop_q[i]  <= 1'b0;
                fifo_eop_q[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= ram_readdata;
                fifo_sop_q[wr_ptr_q]  <= infl_sop_q;
                fifo_eop_q[wr_ptr_q]  <= infl_eop_q;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Output mapping; flags are masked so a stale head never looks like a boundary.
    always_comb begin
        busy           = (state_q != StIdle);
        done           = done_q;
        ram_address    = addr_q;
        ram_chipselect = req;
        ram_write      = 1'b0;
        ram_byteenable = '1;
        ram_clken      = 1'b1;
        st_data        = fifo_data_q[rd_ptr_q];
        st_sop         = st_valid && fifo_sop_q[rd_ptr_q];
        st_eop         = st_valid && fifo_eop_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_blk_e53820.sv
// Self-checking bench for blk_e53820: a RAM model with 1-cycle read latency,
// a scoreboard of expected read addresses and stream beats, and directed tests.
module tb_blk_e53820;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] word_count;
    logic        busy;
    logic        done;
    logic [11:0] ram_address;
    logic        ram_chipselect;
    logic        ram_write;
    logic [3:0]  ram_byteenable;
    logic        ram_clken;
    logic [31:0] ram_readdata = 32'h0;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic        st_sop;
    logic        st_eop;

    blk_e53820 dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_byteenable (ram_byteenable),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_sop         (st_sop),
        .st_eop         (st_eop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // RAM image: every word embeds its own address so order errors are visible.
    function automatic logic [31:0] img(input logic [11:0] a);
        return {4'hB, a, a ^ 12'h9C3, 4'h6};
    endfunction

    always @(posedge clk) begin
        if (ram_chipselect) ram_readdata <= img(ram_address);
    end

    logic [11:0] exp_addr[$];
    logic [33:0] exp_beat[$];

    int checks = 0;
    int fails = 0;
    int req_cnt = 0;
    int beat_cnt = 0;
    int sop_cnt = 0;
    int eop_cnt = 0;
    int done_cnt = 0;
    int sop_cyc = 0;
    int eop_cyc = 0;
    int done_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare RAM requests and stream beats against the scoreboard.
    always @(negedge clk) begin
        if (ram_chipselect) begin
            req_cnt++;
            chk("read_expected", 64'(exp_addr.size() > 0), 64'd1);
            if (exp_addr.size() > 0) chk("read_addr", 64'(ram_address), 64'(exp_addr.pop_front()));
        end
        if (st_valid && st_ready) begin
            beat_cnt++;
            if (st_sop) begin sop_cnt++; sop_cyc = cyc; end
            if (st_eop) begin eop_cnt++; eop_cyc = cyc; end
            chk("beat_expected", 64'(exp_beat.size() > 0), 64'd1);
            if (exp_beat.size() > 0) chk("beat", 64'({st_data, st_sop, st_eop}), 64'(exp_beat.pop_front()));
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push expectations, then pulse start for one cycle.
    task automatic go(input logic [11:0] b, input logic [12:0] n);
        int ni = int'(n);
        for (int i = 0; i < ni; i++) begin
            logic [11:0] a = 12'(int'(b) + i);
            exp_addr.push_back(a);
            exp_beat.push_back({img(a), i == 0, i == ni - 1});
        end
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int k;
        reset      = 1'b1;
        start      = 1'b0;
        st_ready   = 1'b0;
        base_addr  = '0;
        word_count = '0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(st_valid), 64'd0);
        chk("rst_cs", 64'(ram_chipselect), 64'd0);
        chk("rst_write", 64'(ram_write), 64'd0);
        chk("rst_be", 64'(ram_byteenable), 64'hF);
        chk("rst_clken", 64'(ram_clken), 64'd1);
        chk("rst_data", 64'(st_data), 64'd0);
        chk("rst_flags", 64'({st_sop, st_eop}), 64'd0);
        chk("rst_addr", 64'(ram_address), 64'd0);
        step();
        reset = 1'b0;
        step();

        // Test 1: basic transfer, latency and back-to-back beats.
        st_ready = 1'b1;
        req_cnt  = 0;
        d0       = done_cnt;
        go(12'h010, 13'd8);
        @(negedge clk);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_valid_n1", 64'(st_valid), 64'd0);
        step();
        @(negedge clk);
        chk("t1_valid_n2", 64'(st_valid), 64'd0);
        step();
        @(negedge clk);
        chk("t1_valid_n3", 64'(st_valid), 64'd1);
        chk("t1_sop_n3", 64'(st_sop), 64'd1);
        wait_done(50, "t1");
        chk("t1_done_lat", 64'(done_cyc), 64'(eop_cyc + 1));
        chk("t1_no_bubble", 64'(eop_cyc - sop_cyc), 64'd7);
        chk("t1_reads", 64'(req_cnt), 64'd8);
        chk("t1_queue", 64'(exp_beat.size() + exp_addr.size()), 64'd0);
        @(negedge clk);
        chk("t1_pulse", 64'({busy, done}), 64'd0);
        chk("t1_done_once", 64'(done_cnt - d0), 64'd1);

        // Test 2: address wrap at the top of the RAM.
        go(12'hFFE, 13'd4);
        wait_done(50, "t2");
        chk("t2_queue", 64'(exp_beat.size() + exp_addr.size()), 64'd0);

        // Test 3: stalled sink, credit limit, and start ignored while busy.
        st_ready = 1'b0;
        req_cnt  = 0;
        beat_cnt = 0;
        go(12'h200, 13'd16);
        repeat (5) step();
        base_addr  = 12'h300;
        word_count = 13'd5;
        start      = 1'b1;
        step();
        start = 1'b0;
        repeat (13) step();
        @(negedge clk);
        chk("t3_stalled_reads", 64'(req_cnt), 64'd4);
        chk("t3_stalled_beats", 64'(beat_cnt), 64'd0);
        chk("t3_valid_held", 64'(st_valid), 64'd1);
        st_ready = 1'b1;
        wait_done(100, "t3");
        chk("t3_reads", 64'(req_cnt), 64'd16);
        chk("t3_beats", 64'(beat_cnt), 64'd16);
        chk("t3_queue", 64'(exp_beat.size() + exp_addr.size()), 64'd0);

        // Test 4: full RAM sweep with random backpressure.
        d0       = done_cnt;
        sop_cnt  = 0;
        eop_cnt  = 0;
        beat_cnt = 0;
        go(12'h000, 13'h1000);
        k = 0;
        while (done_cnt == d0 && k < 20000) begin
            st_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        st_ready = 1'b1;
        repeat (4) step();
        chk("t4_done_once", 64'(done_cnt - d0), 64'd1);
        chk("t4_beats", 64'(beat_cnt), 64'd4096);
        chk("t4_sop", 64'(sop_cnt), 64'd1);
        chk("t4_eop", 64'(eop_cnt), 64'd1);
        chk("t4_queue", 64'(exp_beat.size() + exp_addr.size()), 64'd0);

        // Test 5: zero-length and single-word transfers.
        req_cnt = 0;
        d0      = done_cnt;
        go(12'h055, 13'd0);
        @(negedge clk);
        chk("t5_zero_done", 64'(done), 64'd1);
        chk("t5_zero_busy", 64'(busy), 64'd0);
        repeat (4) step();
        chk("t5_zero_reads", 64'(req_cnt), 64'd0);
        chk("t5_zero_once", 64'(done_cnt - d0), 64'd1);
        beat_cnt = 0;
        go(12'h7A0, 13'd1);
        wait_done(50, "t5_one");
        chk("t5_one_beats", 64'(beat_cnt), 64'd1);
        chk("t5_one_queue", 64'(exp_beat.size() + exp_addr.size()), 64'd0);

        // Test 6: reset in mid-transfer, then a clean transfer.
        beat_cnt = 0;
        d0       = done_cnt;
        go(12'h100, 13'd10);
        k = 0;
        while (beat_cnt < 5 && k < 50) begin
            step();
            k++;
        end
        chk("t6_reached_5", 64'(beat_cnt >= 5), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_addr.delete();
        exp_beat.delete();
        @(negedge clk);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_valid", 64'(st_valid), 64'd0);
        chk("t6_rst_cs", 64'(ram_chipselect), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        chk("t6_rst_outs", 64'({ram_address, st_sop, st_eop}), 64'd0);
        repeat (5) step();
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t6_idle_valid", 64'(st_valid), 64'd0);
        req_cnt = 0;
        go(12'h010, 13'd8);
        wait_done(50, "t6_rerun");
        chk("t6_done_lat", 64'(done_cyc), 64'(eop_cyc + 1));
        chk("t6_no_bubble", 64'(eop_cyc - sop_cyc), 64'd7);
        chk("t6_reads", 64'(req_cnt), 64'd8);
        chk("t6_queue", 64'(exp_beat.size() + exp_addr.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
